// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage. It keeps the program counter and the IF/ID
//   register, and inserts stall bubbles for hazard control.
//
//   Two states:
//     RUN  - fetch every cycle.
//     HOLD - issue bubbles while the PC is held. A counted stall loads cnt
//            and decrements it each cycle. A jump stall (jwait) waits for a
//            redirect.
//   Redirect has priority over stall, and stall has priority over a normal
//   fetch, in either state.
//
// Ports
//   CLK            in   clock, rising-edge
//   RST_N          in   asynchronous active-low reset
//   InstrMem       in   [31:0] instruction memory data at address PC
//   StallIn        in   stall request from hazard control
//   StallCountIn   in   [31:0] extra bubble count (taken on RUN->HOLD only)
//   Redirect       in   taken branch/jump resolved downstream
//   RedirectTarget in   [31:0] new fetch address when Redirect=1
//   PC             out  [31:0] registered fetch address
//   InstrOut       out  [31:0] IF/ID instruction
//   PCPlus4Out     out  [31:0] PC+4 of the instruction in InstrOut
//   StallOut       out  stall feedback to hazard control
//   StallCountOut  out  [31:0] remaining count feedback (0 outside HOLD)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] BUBBLE   = 32'hFC000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] InstrMem,
    input  logic        StallIn,
    input  logic [31:0] StallCountIn,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] PC,
    output logic [31:0] InstrOut,
    output logic [31:0] PCPlus4Out,
    output logic        StallOut,
    output logic [31:0] StallCountOut
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic        jwait, jwait_n;
    logic [31:0] pc_n, instr_n, pc4_n;
    logic [31:0] pc_inc;
    logic        is_jump;

    assign pc_inc = PC + 32'd4;

    // The instruction being stalled behind determines whether the stall must
    // wait for the redirect: j, jal, or jr (SPECIAL opcode with funct 001000).
    assign is_jump = (InstrOut[31:26] == 6'b000010) ||
                     (InstrOut[31:26] == 6'b000011) ||
                     ((InstrOut[31:26] == 6'b000000) && (InstrOut[5:0] == 6'b001000));

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= RUN;
            cnt        <= 32'd0;
            jwait      <= 1'b0;
            PC         <= RESET_PC;
            InstrOut   <= BUBBLE;
            PCPlus4Out <= 32'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            jwait      <= jwait_n;
            PC         <= pc_n;
            InstrOut   <= instr_n;
            PCPlus4Out <= pc4_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        jwait_n = jwait;
        pc_n    = PC;
        instr_n = InstrOut;
        pc4_n   = PCPlus4Out;

        if (Redirect) begin
            // Flush: the instruction in IF/ID is on the wrong path.
            state_n = RUN;
            cnt_n   = 32'd0;
            jwait_n = 1'b0;
            pc_n    = RedirectTarget;
            instr_n = BUBBLE;
            pc4_n   = 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (StallIn) begin
                        state_n = HOLD;
                        cnt_n   = StallCountIn;
                        jwait_n = (StallCountIn == 32'd0) && is_jump;
                        instr_n = BUBBLE;
                    end else begin
                        pc_n    = pc_inc;
                        instr_n = InstrMem;
                        pc4_n   = pc_inc;
                    end
                end
                HOLD: begin
                    if (cnt != 32'd0) begin
                        cnt_n   = cnt - 32'd1;
                        instr_n = BUBBLE;
                    end else if (jwait || StallIn) begin
                        instr_n = BUBBLE;
                    end else begin
                        // Leaving HOLD fetches in the same cycle, so no
                        // address is skipped and no extra bubble is added.
                        state_n = RUN;
                        pc_n    = pc_inc;
                        instr_n = InstrMem;
                        pc4_n   = pc_inc;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    // Outputs
    always_comb begin
        StallOut      = 1'b0;
        StallCountOut = 32'd0;
        if (state == HOLD) begin
            StallOut      = (cnt != 32'd0) || jwait;
            StallCountOut = cnt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] BUB    = 32'hFC000000;
    localparam logic [31:0] BEQ_W  = 32'h10220005;
    localparam logic [31:0] JR_W   = 32'h03E00008;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] InstrMem;
    logic        StallIn;
    logic [31:0] StallCountIn;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] PC;
    logic [31:0] InstrOut;
    logic [31:0] PCPlus4Out;
    logic        StallOut;
    logic [31:0] StallCountOut;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        stall;
        logic [31:0] scnt;
    } exp_t;

    exp_t sbq[$];

    fetch_stage dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .InstrMem      (InstrMem),
        .StallIn       (StallIn),
        .StallCountIn  (StallCountIn),
        .Redirect      (Redirect),
        .RedirectTarget(RedirectTarget),
        .PC            (PC),
        .InstrOut      (InstrOut),
        .PCPlus4Out    (PCPlus4Out),
        .StallOut      (StallOut),
        .StallCountOut (StallCountOut)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: lw-style words carrying the address, plus a beq and
    // a jr at fixed addresses.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h10) return BEQ_W;
        if (a == 32'h20) return JR_W;
        return {6'b100011, a[25:0]};
    endfunction

    assign InstrMem = mem(PC);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".pc"},    PC,                    32'h0);
        chk({tag, ".instr"}, InstrOut,              BUB);
        chk({tag, ".pc4"},   PCPlus4Out,            32'h0);
        chk({tag, ".stall"}, {31'b0, StallOut},     32'h0);
        chk({tag, ".scnt"},  StallCountOut,         32'h0);
    endtask

    // Drive one cycle of inputs, record what the stage must show after the
    // edge, then compare once the edge has happened.
    task automatic step(input string tag, input logic s, input logic [31:0] sc,
                        input logic r, input logic [31:0] t,
                        input logic [31:0] epc, input logic [31:0] ein,
                        input logic [31:0] ep4, input logic est,
                        input logic [31:0] esc);
        exp_t e;
        StallIn        = s;
        StallCountIn   = sc;
        Redirect       = r;
        RedirectTarget = t;
        e.tag = tag; e.pc = epc; e.instr = ein; e.pc4 = ep4; e.stall = est; e.scnt = esc;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        chk({e.tag, ".pc"},    PC,                e.pc);
        chk({e.tag, ".instr"}, InstrOut,          e.instr);
        chk({e.tag, ".pc4"},   PCPlus4Out,        e.pc4);
        chk({e.tag, ".stall"}, {31'b0, StallOut}, {31'b0, e.stall});
        chk({e.tag, ".scnt"},  StallCountOut,     e.scnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; StallIn = 1'b0; StallCountIn = 32'd0;
        Redirect = 1'b0; RedirectTarget = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("reset");
        RST_N = 1'b1;

        // Sequential fetch
        step("seq0", 0, 0, 0, 0, 32'h04, mem(32'h00), 32'h04, 0, 0);
        step("seq1", 0, 0, 0, 0, 32'h08, mem(32'h04), 32'h08, 0, 0);
        step("seq2", 0, 0, 0, 0, 32'h0C, mem(32'h08), 32'h0C, 0, 0);
        step("seq3", 0, 0, 0, 0, 32'h10, mem(32'h0C), 32'h10, 0, 0);
        step("seq4", 0, 0, 0, 0, 32'h14, BEQ_W,       32'h14, 0, 0);

        // Counted stall behind beq: three bubbles, then resume at held PC
        step("cnt0", 1, 2, 0, 0, 32'h14, BUB,         32'h14, 1, 2);
        step("cnt1", 0, 0, 0, 0, 32'h14, BUB,         32'h14, 1, 1);
        step("cnt2", 0, 0, 0, 0, 32'h14, BUB,         32'h14, 0, 0);
        step("cnt3", 0, 0, 0, 0, 32'h18, mem(32'h14), 32'h18, 0, 0);
        step("cnt4", 0, 0, 0, 0, 32'h1C, mem(32'h18), 32'h1C, 0, 0);

        // Redirect during the second bubble, with StallIn also high
        step("rd0",  0, 0, 1, 32'h10, 32'h10, BUB,    32'h0,  0, 0);
        step("rd1",  0, 0, 0, 0, 32'h14, BEQ_W,       32'h14, 0, 0);
        step("rd2",  1, 2, 0, 0, 32'h14, BUB,         32'h14, 1, 2);
        step("rd3",  1, 7, 1, 32'h40, 32'h40, BUB,    32'h0,  0, 0);
        step("rd4",  0, 0, 0, 0, 32'h44, mem(32'h40), 32'h44, 0, 0);

        // jr with zero count: hold until the redirect
        step("jr0",  0, 0, 1, 32'h20, 32'h20, BUB,    32'h0,  0, 0);
        step("jr1",  0, 0, 0, 0, 32'h24, JR_W,        32'h24, 0, 0);
        step("jr2",  1, 0, 0, 0, 32'h24, BUB,         32'h24, 1, 0);
        for (int i = 0; i < 10; i++)
            step("jrw", 0, 0, 0, 0, 32'h24, BUB,      32'h24, 1, 0);
        step("jr3",  0, 0, 1, 32'h100, 32'h100, BUB,  32'h0,  0, 0);
        step("jr4",  0, 0, 0, 0, 32'h104, mem(32'h100), 32'h104, 0, 0);

        // Load-use stall: zero count, non-jump
        step("lu0",  1, 0, 0, 0, 32'h104, BUB,        32'h104, 0, 0);
        step("lu1",  1, 0, 0, 0, 32'h104, BUB,        32'h104, 0, 0);
        step("lu2",  0, 0, 0, 0, 32'h108, mem(32'h104), 32'h108, 0, 0);

        // StallCountIn is ignored once in HOLD
        step("ign0", 1, 3, 0, 0, 32'h108, BUB,        32'h108, 1, 3);
        step("ign1", 1, 9, 0, 0, 32'h108, BUB,        32'h108, 1, 2);
        step("ign2", 0, 0, 0, 0, 32'h108, BUB,        32'h108, 1, 1);
        step("ign3", 0, 0, 0, 0, 32'h108, BUB,        32'h108, 0, 0);
        step("ign4", 0, 0, 0, 0, 32'h10C, mem(32'h108), 32'h10C, 0, 0);

        // Async reset while holding with cnt=5
        step("hr0",  1, 5, 0, 0, 32'h10C, BUB,        32'h10C, 1, 5);
        StallIn = 1'b0;
        RST_N = 1'b0;
        #1;
        check_reset("areset");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step("hr1",  0, 0, 0, 0, 32'h04, mem(32'h00), 32'h04, 0, 0);

        // PC wrap
        step("wr0",  0, 0, 1, 32'hFFFFFFF8, 32'hFFFFFFF8, BUB, 32'h0, 0, 0);
        step("wr1",  0, 0, 0, 0, 32'hFFFFFFFC, mem(32'hFFFFFFF8), 32'hFFFFFFFC, 0, 0);
        step("wr2",  0, 0, 0, 0, 32'h00000000, mem(32'hFFFFFFFC), 32'h00000000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter BUBBLE, default 32'hFC000000, the stall-opcode bubble (opcode 6'b111111) issued into IF/ID.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 InstrMem  in  32  instruction memory read data for address PC (combinational).
REQ-006 StallIn  in  1  stall request from hazard control.
REQ-007 StallCountIn  in  32  extra bubble count from hazard control.
REQ-008 Redirect  in  1  taken branch/jump resolved downstream.
REQ-009 RedirectTarget  in  32  new fetch address, valid when Redirect=1.
REQ-010 PC  out  32  current fetch address to instruction memory (registered).
REQ-011 InstrOut  out  32  IF/ID instruction (registered); nextInstr source for hazard control is InstrMem.
REQ-012 PCPlus4Out  out  32  PC+4 of the instruction in InstrOut (registered).
REQ-013 StallOut  out  1  fed back to hazard control stall input.
REQ-014 StallCountOut  out  32  fed back to hazard control count input.

Function
REQ-015 Two states: RUN, HOLD; internal regs cnt[31:0], jwait[0:0].
REQ-016 Priority at every edge: Redirect > StallIn > normal fetch.
REQ-017 Any state, Redirect=1: PC<=RedirectTarget, InstrOut<=BUBBLE, PCPlus4Out<=0, cnt<=0, jwait<=0, state<=RUN.
REQ-018 RUN, StallIn=1: PC held, InstrOut<=BUBBLE, PCPlus4Out held, cnt<=StallCountIn, state<=HOLD.
REQ-019 On RUN->HOLD, jwait<=1 iff StallCountIn==0 and current InstrOut is j (6'b000010), jal (6'b000011) or jr (opcode 0, funct 6'b001000); else jwait<=0.
REQ-020 RUN, StallIn=0: InstrOut<=InstrMem, PCPlus4Out<=PC+4, PC<=PC+4 (32-bit wrap, 32'hFFFFFFFC -> 0).
REQ-021 HOLD, cnt!=0: cnt<=cnt-1, InstrOut<=BUBBLE, PC held.
REQ-022 HOLD, cnt==0, jwait=1: remain HOLD issuing BUBBLE until Redirect.
REQ-023 HOLD, cnt==0, jwait=0, StallIn=1: remain HOLD issuing BUBBLE.
REQ-024 HOLD, cnt==0, jwait=0, StallIn=0: exit acts as RUN fetch (REQ-020 update) and state<=RUN in the same edge.
REQ-025 StallOut = (state==HOLD) && (cnt!=0 || jwait); combinational from registers.
REQ-026 StallCountOut = cnt when state==HOLD, else 0.
REQ-027 cnt never decrements below 0; StallCountIn accepted only on RUN->HOLD, ignored in HOLD.
REQ-028 Redirect and StallIn asserted same edge: Redirect wins, StallIn ignored that cycle.

Reset
REQ-029 RST_N=0 immediately: PC=RESET_PC, InstrOut=BUBBLE, PCPlus4Out=0, state=RUN, cnt=0, jwait=0, StallOut=0, StallCountOut=0.
REQ-030 Reset asserted mid-HOLD discards cnt/jwait; first edge after release fetches RESET_PC.

Verification
REQ-031 Reset release, StallIn=0, 3 edges -> PC 0->4->8->12; InstrOut = mem[0],mem[4],mem[8]; PCPlus4Out 4,8,12.
REQ-032 InstrOut=beq, StallIn=1, StallCountIn=2, no Redirect -> StallCountOut 2,1,0, StallOut 1,1,0; 3 BUBBLEs; PC held then fetch resumes at held PC.
REQ-033 Same as 032 with Redirect=1, RedirectTarget=32'h40 during second bubble -> PC=32'h40, state RUN, StallOut=0 next cycle.
REQ-034 InstrOut=jr, StallIn=1, StallCountIn=0 -> HOLD, StallOut=1 for 10 cycles with no Redirect; Redirect to 32'h100 -> PC=32'h100, StallOut=0.
REQ-035 Load-use: StallIn=1, StallCountIn=0, non-jump -> one BUBBLE, StallOut=0; StallIn held 1 one more cycle -> second BUBBLE; StallIn=0 -> fetch resumes, no address skipped.
REQ-036 RST_N pulsed low while HOLD with cnt=5 -> all outputs at REQ-029 values asynchronously; PC wrap check 32'hFFFFFFFC -> 0.
